// File: rtl/regfile_wr_arbiter_if.sv
// Handshake and write-port bundle shared by the register-file write arbiter and its requesters.
// Master drives requests and clr_start; slave (the arbiter) drives readies and the rf_* port.
interface regfile_wr_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              clr_start;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [1:0]        wr_src;
  logic              busy;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, clr_start,
    input  req0_ready, req1_ready, rf_wr_en, rf_wr_addr, rf_wr_data, wr_src, busy
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, clr_start,
    output req0_ready, req1_ready, rf_wr_en, rf_wr_addr, rf_wr_data, wr_src, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a clear sweep that
// zeroes every register after reset or on clr_start while holding off both requesters.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREGS  = 16
) (
  input logic               clk,
  input logic               clr,
  regfile_wr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StClear, StArb} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              last_q;
  logic              gnt_valid;
  logic              gnt_id;
  logic              arb_open;

  // Tie goes to the port that did not win most recently.
  always_comb begin
    gnt_valid = bus.req0_valid | bus.req1_valid;
    gnt_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_q;
    end else if (bus.req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign arb_open       = (state_q == StArb) && !bus.clr_start;
  assign bus.req0_ready = arb_open && gnt_valid && !gnt_id;
  assign bus.req1_ready = arb_open && gnt_valid && gnt_id;
  assign bus.busy       = (state_q == StClear);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q        <= StClear;
      cnt_q          <= '0;
      last_q         <= 1'b1;
      bus.rf_wr_en   <= 1'b0;
      bus.rf_wr_addr <= '0;
      bus.rf_wr_data <= '0;
      bus.wr_src     <= 2'b00;
    end else begin
      unique case (state_q)
        StClear: begin
          bus.rf_wr_en   <= 1'b1;
          bus.rf_wr_addr <= cnt_q;
          bus.rf_wr_data <= '0;
          bus.wr_src     <= 2'b00;
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == ADDR_W'(NREGS - 1)) begin
            state_q <= StArb;
          end
        end
        StArb: begin
          if (bus.clr_start) begin
            bus.rf_wr_en <= 1'b0;
            cnt_q        <= '0;
            state_q      <= StClear;
          end else if (gnt_valid) begin
            bus.rf_wr_en   <= 1'b1;
            bus.rf_wr_addr <= gnt_id ? bus.req1_addr : bus.req0_addr;
            bus.rf_wr_data <= gnt_id ? bus.req1_data : bus.req0_data;
            bus.wr_src     <= {gnt_id, ~gnt_id};
            last_q         <= gnt_id;
          end else begin
            bus.rf_wr_en <= 1'b0;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: clear sweeps, single-port writes, contention,
// same-address ordering, clr_start collision and asynchronous reset mid-sweep.
module tb_regfile_wr_arbiter;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_wr_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(4), .NREGS(16)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a full 16-write sweep starting at the next edge; expects readies held low meanwhile.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_rdy0"}, 32'(bus.req0_ready), 32'd0);
      check({tag, "_rdy1"}, 32'(bus.req1_ready), 32'd0);
      tick();
      check({tag, "_en"},   32'(bus.rf_wr_en), 32'd1);
      check({tag, "_addr"}, 32'(bus.rf_wr_addr), 32'(i));
      check({tag, "_data"}, bus.rf_wr_data, 32'd0);
      check({tag, "_src"},  32'(bus.wr_src), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), (i == 15) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd0;
    bus.req0_data  = 32'd0;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd0;
    bus.req1_data  = 32'd0;
    bus.clr_start  = 1'b0;
    #12;
    // Reset state, with requests presented to prove readies stay low.
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_en",   32'(bus.rf_wr_en), 32'd0);
    check("rst_addr", 32'(bus.rf_wr_addr), 32'd0);
    check("rst_data", bus.rf_wr_data, 32'd0);
    check("rst_src",  32'(bus.wr_src), 32'd0);
    check("rst_rdy0", 32'(bus.req0_ready), 32'd0);
    check("rst_rdy1", 32'(bus.req1_ready), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    check_sweep("sweep0");
    tick();
    check("idle_en", 32'(bus.rf_wr_en), 32'd0);

    // Contention: port 0 wins first tie, then strict alternation.
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd1; bus.req0_data = 32'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd2; bus.req1_data = 32'h22;
    #1;
    for (int t = 0; t < 8; t++) begin
      check("cont_rdy0", 32'(bus.req0_ready), (t % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_rdy1", 32'(bus.req1_ready), (t % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("cont_en",   32'(bus.rf_wr_en), 32'd1);
      check("cont_src",  32'(bus.wr_src), (t % 2 == 0) ? 32'd1 : 32'd2);
      check("cont_addr", 32'(bus.rf_wr_addr), (t % 2 == 0) ? 32'd1 : 32'd2);
      check("cont_data", bus.rf_wr_data, (t % 2 == 0) ? 32'h11 : 32'h22);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check("cont_idle", 32'(bus.rf_wr_en), 32'd0);

    // Same address on both ports: two writes, port 0 first.
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd7; bus.req0_data = 32'hAAAA0000;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd7; bus.req1_data = 32'h0000BBBB;
    #1;
    check("same_rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    check("same_addr0", 32'(bus.rf_wr_addr), 32'd7);
    check("same_data0", bus.rf_wr_data, 32'hAAAA0000);
    check("same_src0",  32'(bus.wr_src), 32'd1);
    bus.req0_valid = 1'b0;
    #1;
    check("same_rdy1", 32'(bus.req1_ready), 32'd1);
    tick();
    check("same_en1",   32'(bus.rf_wr_en), 32'd1);
    check("same_addr1", 32'(bus.rf_wr_addr), 32'd7);
    check("same_data1", bus.rf_wr_data, 32'h0000BBBB);
    check("same_src1",  32'(bus.wr_src), 32'd2);
    bus.req1_valid = 1'b0;

    // Single port 0 write, then outputs hold with en low.
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd5; bus.req0_data = 32'hDEADBEEF;
    #1;
    check("single_rdy0", 32'(bus.req0_ready), 32'd1);
    check("single_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    check("single_en",   32'(bus.rf_wr_en), 32'd1);
    check("single_addr", 32'(bus.rf_wr_addr), 32'd5);
    check("single_data", bus.rf_wr_data, 32'hDEADBEEF);
    check("single_src",  32'(bus.wr_src), 32'd1);
    bus.req0_valid = 1'b0;
    tick();
    check("hold_en",   32'(bus.rf_wr_en), 32'd0);
    check("hold_addr", 32'(bus.rf_wr_addr), 32'd5);
    check("hold_data", bus.rf_wr_data, 32'hDEADBEEF);
    check("hold_src",  32'(bus.wr_src), 32'd1);

    // clr_start collides with a port-1 request; request is served after the sweep.
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd3; bus.req1_data = 32'h33;
    bus.clr_start  = 1'b1;
    #1;
    check("col_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.clr_start = 1'b0;
    check("col_busy", 32'(bus.busy), 32'd1);
    check("col_en",   32'(bus.rf_wr_en), 32'd0);
    check_sweep("sweep1");
    check("col_rdy1_after", 32'(bus.req1_ready), 32'd1);
    tick();
    check("col_en_after",   32'(bus.rf_wr_en), 32'd1);
    check("col_addr_after", 32'(bus.rf_wr_addr), 32'd3);
    check("col_data_after", bus.rf_wr_data, 32'h33);
    check("col_src_after",  32'(bus.wr_src), 32'd2);
    bus.req1_valid = 1'b0;

    // Async reset while the sweep is writing address 9.
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_addr9", 32'(bus.rf_wr_addr), 32'd9);
    #2;
    clr = 1'b0;
    #1;
    check("arst_en",   32'(bus.rf_wr_en), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd1);
    check("arst_addr", 32'(bus.rf_wr_addr), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    tick();
    check("restart_en",   32'(bus.rf_wr_en), 32'd1);
    check("restart_addr", 32'(bus.rf_wr_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter and clear sequencer for the 16 x 32-bit register file. It shares the register file's single write port between two requesters (ALU writeback on port 0, memory-load writeback on port 1) using valid/ready handshakes and round-robin arbitration. After reset, or on a software request, it zeroes every register by issuing one write per cycle, and stalls both requesters until the sweep is complete.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register address width
- NREGS, 16, number of registers swept by a clear; must be ≤ 2^ADDR_W

Ports:
- clk  in  1  clock; all state changes on the rising edge
- clr  in  1  reset, asynchronous, active-low
- req0_valid  in  1  port-0 write request
- req0_addr  in  ADDR_W  port-0 target register
- req0_data  in  DATA_W  port-0 write data
- req0_ready  out  1  port-0 accepted this cycle
- req1_valid / req1_addr / req1_data / req1_ready  same as port 0, for port 1
- clr_start  in  1  single-cycle pulse requesting a full clear sweep
- rf_wr_en  out  1  register-file write strobe
- rf_wr_addr  out  ADDR_W  register-file write address
- rf_wr_data  out  DATA_W  register-file write data
- wr_src  out  2  source of the current write: 00 clear, 01 port 0, 10 port 1
- busy  out  1  high while a clear sweep is in progress

## Operation
- States: CLEAR, ARB. State is registered, and busy = (state == CLEAR).
- CLEAR:
  - Counter cnt starts at 0.
  - Each cycle, the block registers rf_wr_en=1, rf_wr_addr=cnt, rf_wr_data=0, wr_src=00, then increments cnt.
  - In the cycle with cnt == NREGS-1, the next state is ARB.
  - Both readies are 0 throughout. clr_start is ignored in this state.
- ARB:
  - reqN_ready is combinational: state==ARB && !clr_start && grant==N.
  - Grant rule:
    - Only one valid: that port is granted.
    - Both valid: the port not granted most recently wins.
    - Neither valid: no grant.
  - Transfer occurs when reqN_valid && reqN_ready at a rising edge. On that edge:
    - rf_wr_en=1, rf_wr_addr=reqN_addr, rf_wr_data=reqN_data, wr_src=N+1.
    - The last-grant pointer is set to N.
  - With no transfer, rf_wr_en=0 on that edge. rf_wr_addr, rf_wr_data and wr_src hold their previous values.
  - clr_start in ARB: no grant in that cycle, cnt is set to 0, and the next state is CLEAR.
- Requester rules:
  - Once asserted, valid stays high and addr/data stay stable until ready.
  - The arbiter never drops a presented request.
- Same address on both ports: both writes are performed, in grant order, on separate cycles. There is no merging or forwarding.
- Address ≥ NREGS from a requester: passed through unchanged. Range checking is the register file's concern.

## Timing
- Reset (clr low, asynchronous):
  - state=CLEAR, cnt=0, busy=1.
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, wr_src=00.
  - Last-grant pointer = port 1, so port 0 wins the first tie.
  - Both readies = 0.
- Reset mid-operation: a clear sweep or pending write is abandoned immediately, and all outputs take the reset values above.
- Clear sweep after clr rises:
  - Edges 1..NREGS carry writes to addresses 0..NREGS-1.
  - The first ready can be asserted in the cycle after edge NREGS, so busy is high for NREGS cycles.
- Write latency: a request accepted at edge k appears as rf_wr_en=1 with its addr/data in the cycle after edge k, for exactly one cycle.
- Throughput: one write per cycle. With both ports continuously valid, grants alternate 0,1,0,1,...
- clr_start in ARB at edge k:
  - The sweep's writes occupy edges k+1 .. k+NREGS.
  - busy rises after edge k and falls after edge k+NREGS.
- No combinational path from rf_* outputs back to any input. readies depend only on state, clr_start, valids and the pointer.

## Test plan
- Reset release: drive clr low then high with no requests.
  - Expect rf_wr_en high for 16 consecutive cycles, addr 0..15, data 0, wr_src 00.
  - busy then falls and readies become eligible.
- Single port: after the clear sweep, req0 addr 5 data 0xDEADBEEF with req1 idle.
  - Expect req0_ready same cycle.
  - Next cycle: rf_wr_en=1, addr 5, data 0xDEADBEEF, wr_src 01.
- Contention: both ports valid continuously, port 0 addr 1 data 0x11, port 1 addr 2 data 0x22, four transfers each.
  - Expect wr_src sequence 01,10,01,10,... with no idle cycles.
  - Port 0 wins the first tie.
- Same address: port 0 writes 0xAAAA0000 and port 1 writes 0x0000BBBB to register 7 simultaneously.
  - Expect two writes to address 7: port 0's first, then port 1's on the next cycle.
- clr_start collision: pulse clr_start in the same cycle req1 is valid.
  - Expect req1_ready=0 and a 16-cycle sweep.
  - req1 is accepted in the first ARB cycle after the sweep.
- Async reset mid-sweep: drop clr at clear address 9.
  - Expect rf_wr_en=0 and busy=1 immediately.
  - After release, the sweep restarts at address 0.
